// File: rtl/mvm_result_collector.sv
// Two-bank ping-pong collector for mvm result vectors, re-issued on a valid/ready stream.
// Optional build macro MVM_COLLECTOR_RELU_EN clamps negative words to zero on capture.
module mvm_result_collector #(
  parameter int MAT_SCALE  = 8,
  parameter int DATA_WIDTH = 24
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         mvm_done,
  input  logic signed [DATA_WIDTH-1:0] mvm_data,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_last,
  output logic                         overflow,
  output logic [1:0]                   banks_used
);

  localparam int IDX_W = (MAT_SCALE > 1) ? $clog2(MAT_SCALE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAT_SCALE - 1);

  typedef enum logic {IDLE, CAPTURE} state_t;

  state_t                  state, state_nxt;
  logic                    done_q;
  logic [IDX_W-1:0]        wr_idx, rd_idx;
  logic                    wr_bank, rd_bank;
  logic [1:0]              full;
  logic [DATA_WIDTH-1:0]   mem [2][MAT_SCALE];
  logic [DATA_WIDTH-1:0]   wr_word;
  logic                    trigger, handshake, drain_release, bank_free;
  logic                    wr_en, cap_last, drop;

  assign trigger       = mvm_done & ~done_q;
  assign out_valid     = full[rd_bank];
  assign out_data      = mem[rd_bank][rd_idx];
  assign out_last      = out_valid && (rd_idx == LAST_IDX);
  assign handshake     = out_valid & out_ready;
  assign drain_release = handshake && (rd_idx == LAST_IDX);
  // A bank draining its last word on this edge frees it for a trigger on the same edge;
  // with both full, wr_bank equals rd_bank, so the freed bank is the one written next.
  assign bank_free     = ~(full[0] & full[1]) | drain_release;
  assign banks_used    = 2'(full[0]) + 2'(full[1]) + 2'(state == CAPTURE);

`ifdef MVM_COLLECTOR_RELU_EN
  assign wr_word = mvm_data[DATA_WIDTH-1] ? '0 : mvm_data;
`else
  assign wr_word = mvm_data;
`endif

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    cap_last  = 1'b0;
    drop      = 1'b0;
    case (state)
      IDLE: begin
        if (trigger) begin
          if (bank_free) state_nxt = CAPTURE;
          else           drop      = 1'b1;
        end
      end
      CAPTURE: begin
        wr_en = 1'b1;
        if (wr_idx == LAST_IDX) begin
          cap_last  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      done_q   <= 1'b0;
      wr_idx   <= '0;
      wr_bank  <= 1'b0;
      rd_idx   <= '0;
      rd_bank  <= 1'b0;
      full     <= '0;
      overflow <= 1'b0;
    end else begin
      done_q <= mvm_done;
      if (drop) overflow <= 1'b1;
      if (wr_en) wr_idx <= cap_last ? '0 : wr_idx + 1'b1;
      if (cap_last) begin
        full[wr_bank] <= 1'b1;
        wr_bank       <= ~wr_bank;
      end
      if (handshake) begin
        if (rd_idx == LAST_IDX) begin
          rd_idx        <= '0;
          full[rd_bank] <= 1'b0;
          rd_bank       <= ~rd_bank;
        end else begin
          rd_idx <= rd_idx + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_bank][wr_idx] <= wr_word;
  end

endmodule
